conv_mac_accum_s2: RTL and testbench
====================================

# conv_mac_accum_s2

Stage-2 multiply-accumulate datapath that sits directly downstream of the stage-2 control FSM. It follows the FSM's `busy_proc` / `dir` / `dir_counter` address stream and consumes the operand pairs returned one cycle later by the synchronous operand memories. For each `dir` group it accumulates 36 signed products and emits one saturated result, so a full pass yields four results. It also flags a frame-done event and any truncated group.

## Interface
- `DW`, 8: signed width of each operand.
- `OUT_W`, 16: signed width of the saturated result.
- `ACC_W`, 2*DW+6: internal accumulator width. This is enough for 36 full-scale products, so no internal overflow.

- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low; clears all state immediately.
- `busy_proc` in 1: from the FSM; address stream is valid this cycle.
- `dir` in 2: from the FSM; group index 0..3.
- `dir_counter` in 6: from the FSM; element index 0..35 within the group.
- `a_data` in DW: signed operand; valid the cycle after its address.
- `b_data` in DW: signed operand; valid the cycle after its address.
- `result` out OUT_W: saturated group sum; holds its value between updates.
- `res_valid` out 1: one-cycle pulse; `result` and `res_idx` are new.
- `res_idx` out 2: `dir` of the group that produced `result`.
- `frame_done` out 1: one-cycle pulse, coincident with the `res_valid` for group 3.
- `seq_err` out 1: sticky flag; a group ended before element 35.

## Operation
- Tag stage T0 registers {`busy_proc`, `dir`, `dir_counter`} every cycle.
  - The operands arriving next cycle are thereby aligned with their tag.
- Multiply stage T1:
  - If the T0 tag is valid, P <= `a_data` * `b_data` as a signed 2*DW product.
  - Tag T1 <= T0. An invalid tag propagates as invalid and P is don't-care.
- Accumulate stage T2, for a valid T1 tag:
  - Element 0: acc <= sext(P). This overwrites, so no explicit clear is needed between groups.
  - Elements 1..35: acc <= acc + sext(P), computed at ACC_W.
  - Element 35: additionally `result` <= sat(acc + P), `res_idx` <= tag `dir`, `res_valid` <= 1.
  - Element 35 with `dir`==3: additionally `frame_done` <= 1.
- Saturation clamps to [-2^(OUT_W-1), 2^(OUT_W-1)-1] and never wraps.
- An invalid T1 tag holds acc and leaves `res_valid` / `frame_done` at 0.
- `seq_err` is set when the T0 tag is valid, its element index is not 35, and the current `busy_proc` is 0 (stream dropped mid-group).
  - The partial acc is never emitted; the next element-0 overwrites it.
- `seq_err` clears when a new pass starts: `busy_proc` rises with `dir`==0 and `dir_counter`==0.
  - If set and clear coincide, clear wins.
- No backpressure: the block accepts one element per cycle unconditionally.

## Timing
- Reset values: `result`=0, `res_valid`=0, `res_idx`=0, `frame_done`=0, `seq_err`=0. The acc, P and all tags are 0, with tags invalid.
- Address with `dir_counter`=35 presented in cycle T:
  - operands arrive in T+1;
  - the product is registered at the end of T+1;
  - `res_valid` is high during T+3.
- Latency from address to result is 3 cycles.
- A full pass of 144 addresses produces `res_valid` pulses 36 cycles apart.
- Back-to-back passes produce no bubbles and no cross-group contamination, because element 0 always overwrites acc.
- Reset asserted mid-pass: all outputs return to 0 immediately and no result is emitted for the interrupted group. After deassertion, a new pass must start at element 0.
- `result` changes only on `res_valid` cycles.

## Test plan
- All 144 operand pairs with a=1, b=1:
  - `res_valid` pulses with `result`=36 and `res_idx`=0,1,2,3;
  - `frame_done` is high only with idx 3.
- a=`dir_counter`, b=2 in group 0:
  - `result`=1260, 3 cycles after the element-35 address.
- a=127, b=127 for a whole group:
  - true sum is 580644, so `result`=32767 (saturated).
- a=-128, b=127 for a whole group:
  - true sum is -585216, so `result`=-32768.
- `busy_proc` dropped after element 20 of group 1:
  - `seq_err`=1 and no `res_valid` for group 1;
  - on the next pass start, `seq_err`=0 and group 0 gives the correct sum.
- `reset` low for 1 cycle during group 2 of pass A, then pass B with a=1, b=1:
  - outputs read 0 during reset and no group-2 result is emitted for pass A;
  - pass B yields four results of 36.

Source files
------------

// File: rtl/conv_mac_accum_s2.sv
`default_nettype none
// ============================================================================
// Module      : conv_mac_accum_s2
// Description : Stage-2 multiply-accumulate datapath. Follows the control
//               FSM address stream, multiplies the operand pairs returned by
//               the synchronous operand memories, sums 36 products per group
//               and emits one saturated result per group.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_mac_accum_s2 #(
    parameter int DW    = 8,
    parameter int OUT_W = 16,
    parameter int ACC_W = 2*DW+6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    busy_proc,
    input  logic [1:0]              dir,
    input  logic [5:0]              dir_counter,
    input  logic signed [DW-1:0]    a_data,
    input  logic signed [DW-1:0]    b_data,
    output logic signed [OUT_W-1:0] result,
    output logic                    res_valid,
    output logic [1:0]              res_idx,
    output logic                    frame_done,
    output logic                    seq_err
);

    localparam logic [5:0] c_LAST_ELEM = 6'd35;
    localparam logic signed [ACC_W-1:0] c_SAT_MAX =
        {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] c_SAT_MIN =
        {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    // T0 tag
    logic                      r_t0_valid;
    logic [1:0]                r_t0_dir;
    logic [5:0]                r_t0_cnt;
    // T1 tag and product
    logic                      r_t1_valid;
    logic [1:0]                r_t1_dir;
    logic [5:0]                r_t1_cnt;
    logic signed [2*DW-1:0]    r_prod;
    // T2 accumulator
    logic signed [ACC_W-1:0]   r_acc;

    logic signed [2*DW-1:0]    w_mul;
    logic signed [ACC_W-1:0]   w_prod_ext;
    logic signed [ACC_W-1:0]   w_sum;
    logic signed [OUT_W-1:0]   w_sat;
    logic                      w_seq_set;
    logic                      w_pass_start;

    assign w_mul      = a_data * b_data;
    assign w_prod_ext = {{(ACC_W-2*DW){r_prod[2*DW-1]}}, r_prod};
    assign w_sum      = r_acc + w_prod_ext;

    // A stream drop leaves a valid non-final tag in T0 while busy is low now.
    assign w_seq_set    = r_t0_valid && (r_t0_cnt != c_LAST_ELEM) && !busy_proc;
    // A pass starts when busy rises on the very first address of group 0.
    assign w_pass_start = busy_proc && !r_t0_valid && (dir == 2'd0) &&
                          (dir_counter == 6'd0);

    // Clamp the group sum into the signed output range
    always_comb begin
        w_sat = w_sum[OUT_W-1:0];
        if (w_sum > c_SAT_MAX) begin
            w_sat = c_SAT_MAX[OUT_W-1:0];
        end else if (w_sum < c_SAT_MIN) begin
            w_sat = c_SAT_MIN[OUT_W-1:0];
        end
    end

    // Tag stage: capture the address so next cycle's operands line up with it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_t0_valid <= 1'b0;
            r_t0_dir   <= 2'd0;
            r_t0_cnt   <= 6'd0;
        end else begin
            r_t0_valid <= busy_proc;
            r_t0_dir   <= dir;
            r_t0_cnt   <= dir_counter;
        end
    end

    // Multiply stage: register product for valid tags, pass tag along
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_t1_valid <= 1'b0;
            r_t1_dir   <= 2'd0;
            r_t1_cnt   <= 6'd0;
            r_prod     <= '0;
        end else begin
            r_t1_valid <= r_t0_valid;
            r_t1_dir   <= r_t0_dir;
            r_t1_cnt   <= r_t0_cnt;
            if (r_t0_valid) begin
                r_prod <= w_mul;
            end
        end
    end

    // Accumulate stage: element 0 overwrites, element 35 also emits the result
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc      <= '0;
            result     <= '0;
            res_valid  <= 1'b0;
            res_idx    <= 2'd0;
            frame_done <= 1'b0;
        end else begin
            res_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (r_t1_valid) begin
                if (r_t1_cnt == 6'd0) begin
                    r_acc <= w_prod_ext;
                end else begin
                    r_acc <= w_sum;
                end
                if (r_t1_cnt == c_LAST_ELEM) begin
                    result     <= w_sat;
                    res_idx    <= r_t1_dir;
                    res_valid  <= 1'b1;
                    frame_done <= (r_t1_dir == 2'd3);
                end
            end
        end
    end

    // Sticky truncated-group flag; a new pass start takes priority
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seq_err <= 1'b0;
        end else if (w_pass_start) begin
            seq_err <= 1'b0;
        end else if (w_seq_set) begin
            seq_err <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv_mac_accum_s2.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_mac_accum_s2
// Description : Directed self-checking bench for conv_mac_accum_s2. Operands
//               are returned one cycle after their address, like the
//               synchronous operand memories.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_mac_accum_s2;

    logic              clk;
    logic              reset;
    logic              busy_proc;
    logic [1:0]        dir;
    logic [5:0]        dir_counter;
    logic signed [7:0] a_data;
    logic signed [7:0] b_data;
    logic signed [15:0] result;
    logic              res_valid;
    logic [1:0]        res_idx;
    logic              frame_done;
    logic              seq_err;

    int total;
    int bad;
    int cyc;
    int pend_a;
    int pend_b;
    int addr35_cyc;
    int spurious_fd;
    int spurious_res;
    logic signed [15:0] prev_result;

    int q_res[$];
    int q_idx[$];
    int q_fd[$];
    int q_cyc[$];

    conv_mac_accum_s2 dut (
        .clk         (clk),
        .reset       (reset),
        .busy_proc   (busy_proc),
        .dir         (dir),
        .dir_counter (dir_counter),
        .a_data      (a_data),
        .b_data      (b_data),
        .result      (result),
        .res_valid   (res_valid),
        .res_idx     (res_idx),
        .frame_done  (frame_done),
        .seq_err     (seq_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every result pulse and any output activity outside a pulse
    always @(negedge clk) begin
        if (res_valid) begin
            q_res.push_back(int'(result));
            q_idx.push_back(int'(res_idx));
            q_fd.push_back(int'(frame_done));
            q_cyc.push_back(cyc);
        end
        if (frame_done && !(res_valid && res_idx == 2'd3)) spurious_fd = spurious_fd + 1;
        if (reset && !res_valid && result !== prev_result) spurious_res = spurious_res + 1;
        prev_result = result;
    end

    function automatic int opa(input int mode, input int cnt);
        case (mode)
            0: return 1;
            1: return cnt;
            2: return 127;
            default: return -128;
        endcase
    endfunction

    function automatic int opb(input int mode);
        case (mode)
            0: return 1;
            1: return 2;
            default: return 127;
        endcase
    endfunction

    // One cycle: present an address, return operands for the previous one
    task automatic step(input logic busy, input int d, input int cnt, input int a, input int b);
        logic [31:0] dv;
        logic [31:0] cv;
        logic [31:0] av;
        logic [31:0] bv;
        dv = d;
        cv = cnt;
        av = pend_a;
        bv = pend_b;
        busy_proc   = busy;
        dir         = dv[1:0];
        dir_counter = cv[5:0];
        a_data      = av[7:0];
        b_data      = bv[7:0];
        pend_a = a;
        pend_b = b;
        if (busy && cnt == 35) addr35_cyc = cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic run_group(input int mode, input int d, input int first, input int last);
        for (int c = first; c <= last; c++) step(1'b1, d, c, opa(mode, c), opb(mode));
    endtask

    task automatic run_pass(input int mode);
        for (int g = 0; g < 4; g++) run_group(mode, g, 0, 35);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0, 0);
    endtask

    task automatic clear_log();
        q_res.delete();
        q_idx.delete();
        q_fd.delete();
        q_cyc.delete();
    endtask

    task automatic test_reset();
        total++; if (result !== 16'sd0) begin bad++; $display("FAIL reset_result got=%0d want=0", result); end
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL reset_res_valid got=%b want=0", res_valid); end
        total++; if (res_idx !== 2'd0) begin bad++; $display("FAIL reset_res_idx got=%0d want=0", res_idx); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done got=%b want=0", frame_done); end
        total++; if (seq_err !== 1'b0) begin bad++; $display("FAIL reset_seq_err got=%b want=0", seq_err); end
    endtask

    task automatic test_ones_pass();
        clear_log();
        run_pass(0);
        idle(5);
        total++; if (q_res.size() != 4) begin bad++; $display("FAIL ones_count got=%0d want=4", q_res.size()); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (i >= q_res.size() || q_res[i] != 36 || q_idx[i] != i || q_fd[i] != (i == 3 ? 1 : 0)) begin
                bad++;
                $display("FAIL ones_result%0d got=%0d idx=%0d fd=%0d want=36 idx=%0d fd=%0d", i,
                         (i < q_res.size()) ? q_res[i] : -1, (i < q_idx.size()) ? q_idx[i] : -1,
                         (i < q_fd.size()) ? q_fd[i] : -1, i, (i == 3) ? 1 : 0);
            end
        end
        for (int i = 1; i < 4; i++) begin
            total++;
            if (i >= q_cyc.size() || q_cyc[i] - q_cyc[i-1] != 36) begin
                bad++;
                $display("FAIL ones_spacing%0d got=%0d want=36", i,
                         (i < q_cyc.size()) ? q_cyc[i] - q_cyc[i-1] : -1);
            end
        end
    endtask

    task automatic test_ramp_latency();
        clear_log();
        run_group(1, 0, 0, 35);
        idle(5);
        total++; if (q_res.size() != 1) begin bad++; $display("FAIL ramp_count got=%0d want=1", q_res.size()); end
        total++;
        if (q_res.size() < 1 || q_res[0] != 1260 || q_idx[0] != 0 || q_fd[0] != 0) begin
            bad++;
            $display("FAIL ramp_result got=%0d want=1260 idx0 fd0", (q_res.size() > 0) ? q_res[0] : -1);
        end
        total++;
        if (q_cyc.size() < 1 || q_cyc[0] - addr35_cyc != 3) begin
            bad++;
            $display("FAIL ramp_latency got=%0d want=3", (q_cyc.size() > 0) ? q_cyc[0] - addr35_cyc : -1);
        end
    endtask

    task automatic test_saturation();
        clear_log();
        run_group(2, 3, 0, 35);
        run_group(3, 0, 0, 35);
        idle(5);
        total++;
        if (q_res.size() < 1 || q_res[0] != 32767 || q_idx[0] != 3 || q_fd[0] != 1) begin
            bad++;
            $display("FAIL sat_pos got=%0d want=32767 idx3 fd1", (q_res.size() > 0) ? q_res[0] : -1);
        end
        total++;
        if (q_res.size() < 2 || q_res[1] != -32768 || q_idx[1] != 0) begin
            bad++;
            $display("FAIL sat_neg got=%0d want=-32768 idx0", (q_res.size() > 1) ? q_res[1] : -1);
        end
    endtask

    task automatic test_back_to_back();
        clear_log();
        run_pass(1);
        run_pass(0);
        idle(5);
        total++; if (q_res.size() != 8) begin bad++; $display("FAIL b2b_count got=%0d want=8", q_res.size()); end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (i >= q_res.size() || q_res[i] != (i < 4 ? 1260 : 36) || q_idx[i] != i % 4) begin
                bad++;
                $display("FAIL b2b_result%0d got=%0d want=%0d", i,
                         (i < q_res.size()) ? q_res[i] : -1, (i < 4) ? 1260 : 36);
            end
        end
    endtask

    task automatic test_seq_err();
        clear_log();
        run_group(0, 0, 0, 35);
        run_group(1, 1, 0, 20);
        idle(6);
        total++; if (seq_err !== 1'b1) begin bad++; $display("FAIL seqerr_set got=%b want=1", seq_err); end
        total++;
        if (q_res.size() != 1 || q_idx[0] != 0) begin
            bad++;
            $display("FAIL seqerr_no_group1 got=%0d results want=1 (group0 only)", q_res.size());
        end
        clear_log();
        step(1'b1, 0, 0, 1, 1);
        total++; if (seq_err !== 1'b0) begin bad++; $display("FAIL seqerr_clear got=%b want=0", seq_err); end
        run_group(0, 0, 1, 35);
        idle(5);
        total++;
        if (q_res.size() != 1 || q_res[0] != 36 || q_idx[0] != 0) begin
            bad++;
            $display("FAIL seqerr_recover got=%0d want=36", (q_res.size() > 0) ? q_res[0] : -1);
        end
    endtask

    task automatic test_reset_midpass();
        clear_log();
        run_group(0, 0, 0, 35);
        run_group(0, 1, 0, 35);
        run_group(0, 2, 0, 10);
        busy_proc = 1'b0;
        reset     = 1'b0;
        pend_a    = 0;
        pend_b    = 0;
        #1;
        total++;
        if (result !== 16'sd0 || res_valid !== 1'b0 || res_idx !== 2'd0 || frame_done !== 1'b0 || seq_err !== 1'b0) begin
            bad++;
            $display("FAIL midreset_outputs got=%0d/%b/%0d/%b/%b want=0/0/0/0/0",
                     result, res_valid, res_idx, frame_done, seq_err);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle(40);
        total++;
        if (q_res.size() != 2) begin
            bad++;
            $display("FAIL midreset_passA got=%0d results want=2", q_res.size());
        end
        clear_log();
        run_pass(0);
        idle(5);
        total++;
        if (q_res.size() != 4 || q_res[0] != 36 || q_res[1] != 36 || q_res[2] != 36 || q_res[3] != 36) begin
            bad++;
            $display("FAIL midreset_passB got=%0d results (first=%0d) want=4 x 36",
                     q_res.size(), (q_res.size() > 0) ? q_res[0] : -1);
        end
    endtask

    task automatic test_quiet_outputs();
        total++; if (spurious_fd != 0) begin bad++; $display("FAIL stray_frame_done got=%0d want=0", spurious_fd); end
        total++; if (spurious_res != 0) begin bad++; $display("FAIL stray_result_change got=%0d want=0", spurious_res); end
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0;
        pend_a = 0; pend_b = 0; addr35_cyc = 0;
        spurious_fd = 0; spurious_res = 0; prev_result = '0;
        reset = 1'b0; busy_proc = 1'b0; dir = 2'd0; dir_counter = 6'd0;
        a_data = '0; b_data = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        reset = 1'b1;
        idle(2);
        test_ones_pass();
        test_ramp_latency();
        test_saturation();
        test_back_to_back();
        test_seq_err();
        test_reset_midpass();
        test_quiet_outputs();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
